adder_share_arb: RTL and testbench

- Shares one combinational WIDTH-bit ripple adder between NREQ requesters.
- Round-robin arbitration over valid/ready request ports; registered operand drive to the adder; captured result returned on a single valid/ready response port tagged with requester ID.
- Sits beside one adder_n-style instance: drives its a/b/cin and samples its sum/cout.

---
 rtl/adder_share_arb.sv | 179 +++++++++++++++++
 tb/tb_adder_share_arb.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arb.sv
// rtl/adder_share_arb.sv - round-robin arbiter sharing one external combinational adder
//
// Purpose:
//   Lets NREQ requesters time-share a single WIDTH-bit adder that sits outside
//   this block. One request is granted at a time. Its operands are registered onto
//   add_*. The adder settles for one full cycle. The result is captured and returned
//   on a single response port, tagged with the requester index.
//
// Optional build macro: ADDER_SHARE_ARB_OVF_EN
//   When defined, adds rsp_ovf, the signed two's-complement overflow of the operation.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester request
//   req_ready  one-hot accept (combinational), zero while in reset
//   req_a/b    packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin    per-requester carry-in
//   add_a/b    registered operands to the shared adder
//   add_cin    registered carry-in to the shared adder
//   add_sum    shared adder sum
//   add_cout   shared adder carry-out
//   rsp_valid  result available
//   rsp_ready  consumer accepts result
//   rsp_sum    captured sum
//   rsp_cout   captured carry-out
//   rsp_ovf    captured signed overflow (optional)
//   rsp_id     requester that owns the result

module adder_share_arb #(
    parameter int WIDTH = 64,
    parameter int NREQ  = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_cin,
    input  logic [WIDTH-1:0]      add_sum,
    input  logic                  add_cout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
`ifdef ADDER_SHARE_ARB_OVF_EN
    output logic                  rsp_ovf,
`endif
    output logic [IDW-1:0]        rsp_id
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADD,
        ST_RESP
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_pend_id;

    logic             w_found;
    logic [IDW-1:0]   w_gnt_id;
    logic             w_can_accept;
    logic             w_hs;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic             w_sel_cin;

    // Round-robin scan in two passes. The first pass covers indices above the
    // pointer. The second pass wraps around to indices up to and including the
    // pointer. This gives the "first valid after rr_ptr, modulo NREQ" order. It also
    // works when NREQ is not a power of two.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i] && (i > int'(r_rr_ptr))) begin
                w_found  = 1'b1;
                w_gnt_id = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i] && (i <= int'(r_rr_ptr))) begin
                w_found  = 1'b1;
                w_gnt_id = IDW'(i);
            end
        end
    end

    // Accept only when no result is pending, or when the pending result leaves
    // this cycle. ADD never accepts.
    assign w_can_accept = (r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready);
    assign w_hs         = w_found && w_can_accept;

    always_comb begin
        req_ready = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_cin = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            // rst_n gates the grant. The async reset forces IDLE, so without this
            // gate req_ready would be asserted while reset is held.
            req_ready[i] = rst_n && w_hs && (w_gnt_id == IDW'(i));
            if (w_gnt_id == IDW'(i)) begin
                w_sel_a   = req_a[i*WIDTH +: WIDTH];
                w_sel_b   = req_b[i*WIDTH +: WIDTH];
                w_sel_cin = req_cin[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= IDW'(NREQ - 1);
            r_pend_id <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= '0;
`ifdef ADDER_SHARE_ARB_OVF_EN
            rsp_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        add_a     <= w_sel_a;
                        add_b     <= w_sel_b;
                        add_cin   <= w_sel_cin;
                        r_pend_id <= w_gnt_id;
                        r_rr_ptr  <= w_gnt_id;
                        r_state   <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    // The adder has settled on the operands registered last cycle.
                    rsp_sum   <= add_sum;
                    rsp_cout  <= add_cout;
                    rsp_id    <= r_pend_id;
                    rsp_valid <= 1'b1;
`ifdef ADDER_SHARE_ARB_OVF_EN
                    rsp_ovf   <= (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                                 (add_sum[WIDTH-1] != add_a[WIDTH-1]);
`endif
                    r_state   <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (w_hs) begin
                            add_a     <= w_sel_a;
                            add_b     <= w_sel_b;
                            add_cin   <= w_sel_cin;
                            r_pend_id <= w_gnt_id;
                            r_rr_ptr  <= w_gnt_id;
                            r_state   <= ST_ADD;
                        end else begin
                            r_state   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_arb.sv
// tb/tb_adder_share_arb.sv - self-checking bench for adder_share_arb

module tb_adder_share_arb;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [255:0] req_a;
    logic [255:0] req_b;
    logic [3:0]   req_cin;
    logic [63:0]  add_a;
    logic [63:0]  add_b;
    logic         add_cin;
    logic [63:0]  add_sum;
    logic         add_cout;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [63:0]  rsp_sum;
    logic         rsp_cout;
    logic [1:0]   rsp_id;
`ifdef ADDER_SHARE_ARB_OVF_EN
    logic         rsp_ovf;
`endif

    logic [63:0]  ta [4];
    logic [63:0]  tbv[4];

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic [1:0]  id;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    assign req_a = {ta[3], ta[2], ta[1], ta[0]};
    assign req_b = {tbv[3], tbv[2], tbv[1], tbv[0]};

    // Shared ripple adder that sits beside the arbiter.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {64'd0, add_cin};

    adder_share_arb #(.WIDTH(64), .NREQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
`ifdef ADDER_SHARE_ARB_OVF_EN
        .rsp_ovf   (rsp_ovf),
`endif
        .rsp_id    (rsp_id)
    );

    function automatic exp_t mk(input logic [63:0] a, input logic [63:0] b,
                                input logic c, input logic [1:0] id);
        exp_t        e;
        logic [64:0] t;
        t      = {1'b0, a} + {1'b0, b} + {64'd0, c};
        e.sum  = t[63:0];
        e.cout = t[64];
        e.id   = id;
        e.ovf  = (a[63] == b[63]) && (t[63] != a[63]);
        return e;
    endfunction

    // Scoreboard consumer. Each response handshake pops one expectation.
    always @(negedge clk) begin
        #2;
        if (rst_n && rsp_valid && rsp_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL rsp_unexpected: got id=%0d sum=%h, required no response", rsp_id, rsp_sum);
            end else begin
                m_e = sb.pop_front();
                if (rsp_sum !== m_e.sum) begin
                    n_bad++;
                    $display("FAIL rsp_sum: got %h, required %h", rsp_sum, m_e.sum);
                end
                n_vec++;
                if (rsp_cout !== m_e.cout) begin
                    n_bad++;
                    $display("FAIL rsp_cout: got %0b, required %0b", rsp_cout, m_e.cout);
                end
                n_vec++;
                if (rsp_id !== m_e.id) begin
                    n_bad++;
                    $display("FAIL rsp_id: got %0d, required %0d", rsp_id, m_e.id);
                end
`ifdef ADDER_SHARE_ARB_OVF_EN
                n_vec++;
                if (rsp_ovf !== m_e.ovf) begin
                    n_bad++;
                    $display("FAIL rsp_ovf: got %0b, required %0b", rsp_ovf, m_e.ovf);
                end
`endif
            end
        end
    end

    task automatic drain();
        int t;
        t = 0;
        rsp_ready = 1'b1;
        while (sb.size() != 0 && t < 20) begin
            @(negedge clk);
            #3;
            t++;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        req_valid = 4'b0000;
        rst_n = 1'b0;
        sb.delete();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        req_cin   = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            ta[i]  = {$urandom, $urandom};
            tbv[i] = {$urandom, $urandom};
        end
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready: got %b, required 0000", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
        n_vec++; if (add_a !== 64'd0) begin n_bad++; $display("FAIL reset_add_a: got %h, required 0", add_a); end
        n_vec++; if (add_b !== 64'd0) begin n_bad++; $display("FAIL reset_add_b: got %h, required 0", add_b); end
        n_vec++; if (add_cin !== 1'b0) begin n_bad++; $display("FAIL reset_add_cin: got %b, required 0", add_cin); end
        n_vec++; if ({rsp_cout, rsp_id, rsp_sum} !== 67'd0) begin n_bad++; $display("FAIL reset_rsp: got cout=%b id=%0d sum=%h, required all 0", rsp_cout, rsp_id, rsp_sum); end
        req_valid = 4'b0000;
        rst_n     = 1'b1;
    endtask

    task automatic test_basic();
        @(negedge clk);
        ta[0] = 64'd5; tbv[0] = 64'd7; req_cin = 4'b0001;
        req_valid = 4'b0001; rsp_ready = 1'b1;
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL basic_grant: got %b, required 0001", req_ready); end
        sb.push_back(mk(64'd5, 64'd7, 1'b1, 2'd0));
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL basic_lat1_valid: got %b, required 0", rsp_valid); end
        n_vec++; if ({add_cin, add_a, add_b} !== {1'b1, 64'd5, 64'd7}) begin n_bad++; $display("FAIL basic_operands: got a=%h b=%h cin=%b, required 5 7 1", add_a, add_b, add_cin); end
        @(negedge clk);
        #1;
        n_vec++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL basic_lat2_valid: got %b, required 1", rsp_valid); end
        n_vec++; if ({rsp_cout, rsp_id, rsp_sum} !== {1'b0, 2'd0, 64'd13}) begin n_bad++; $display("FAIL basic_result: got cout=%b id=%0d sum=%0d, required 0 0 13", rsp_cout, rsp_id, rsp_sum); end
        @(negedge clk);
        #1;
        n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL basic_release: got %b, required 0", rsp_valid); end
        drain();
    endtask

    task automatic test_rotation();
        logic [3:0] er;
        logic       ev;
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            ta[i]  = {$urandom, $urandom};
            tbv[i] = {$urandom, $urandom};
        end
        req_cin = 4'($urandom);
        @(negedge clk);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            er = (c % 2 == 0) ? (4'b0001 << ((c / 2) % 4)) : 4'b0000;
            ev = (c >= 2) && (c % 2 == 0);
            n_vec++; if (req_ready !== er) begin n_bad++; $display("FAIL rot_grant c%0d: got %b, required %b", c, req_ready, er); end
            n_vec++; if (rsp_valid !== ev) begin n_bad++; $display("FAIL rot_valid c%0d: got %b, required %b", c, rsp_valid, ev); end
            if (c % 2 == 0)
                sb.push_back(mk(ta[(c/2)%4], tbv[(c/2)%4], req_cin[(c/2)%4], 2'((c / 2) % 4)));
        end
        @(negedge clk);
        req_valid = 4'b0000;
        drain();
    endtask

    task automatic test_carry();
        logic [63:0] k_a[4];
        logic [63:0] k_b[4];
        logic [1:0]  k_id[4];
        logic [63:0] k_sum[2];
        logic        k_cout[2];
        k_a[0] = 64'hFFFF_FFFF_FFFF_FFFF; k_b[0] = 64'd1; k_id[0] = 2'd3;
        k_a[1] = 64'h7FFF_FFFF_FFFF_FFFF; k_b[1] = 64'd1; k_id[1] = 2'd3;
        k_a[2] = {$urandom, $urandom};     k_b[2] = {$urandom, $urandom}; k_id[2] = 2'd1;
        k_a[3] = 64'h8000_0000_0000_0000; k_b[3] = 64'h8000_0000_0000_0000; k_id[3] = 2'd2;
        k_sum[0] = 64'd0;                    k_cout[0] = 1'b1;
        k_sum[1] = 64'h8000_0000_0000_0000; k_cout[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ta[k_id[i]]  = k_a[i];
            tbv[k_id[i]] = k_b[i];
            req_cin      = 4'b0000;
            req_valid    = 4'b0001 << k_id[i];
            rsp_ready    = 1'b1;
            #1;
            n_vec++; if (req_ready !== (4'b0001 << k_id[i])) begin n_bad++; $display("FAIL carry_grant %0d: got %b, required id %0d", i, req_ready, k_id[i]); end
            sb.push_back(mk(k_a[i], k_b[i], 1'b0, k_id[i]));
            @(negedge clk);
            req_valid = 4'b0000;
            @(negedge clk);
            #1;
            n_vec++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL carry_valid %0d: got %b, required 1", i, rsp_valid); end
            if (i < 2) begin
                n_vec++; if ({rsp_cout, rsp_sum} !== {k_cout[i], k_sum[i]}) begin n_bad++; $display("FAIL carry_const %0d: got cout=%b sum=%h, required cout=%b sum=%h", i, rsp_cout, rsp_sum, k_cout[i], k_sum[i]); end
            end
        end
        drain();
    endtask

    task automatic test_stall();
        exp_t e0;
        pulse_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            ta[i]  = {$urandom, $urandom};
            tbv[i] = {$urandom, $urandom};
        end
        req_cin   = 4'b0101;
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL stall_grant0: got %b, required 0001", req_ready); end
        e0 = mk(ta[0], tbv[0], 1'b1, 2'd0);
        sb.push_back(e0);
        @(negedge clk);
        req_valid = 4'b0110;
        #1;
        n_vec++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL stall_add_nogrant: got %b, required 0000", req_ready); end
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            #1;
            n_vec++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL stall_ready s%0d: got %b, required 0000", s, req_ready); end
            n_vec++; if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd0, e0.sum}) begin n_bad++; $display("FAIL stall_hold s%0d: got v=%b id=%0d sum=%h, required 1 0 %h", s, rsp_valid, rsp_id, rsp_sum, e0.sum); end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        n_vec++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL stall_release_grant: got %b, required 0010", req_ready); end
        sb.push_back(mk(ta[1], tbv[1], 1'b0, 2'd1));
        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        n_vec++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL b2b_add_nogrant: got %b, required 0000", req_ready); end
        @(negedge clk);
        #1;
        n_vec++; if ({rsp_valid, req_ready} !== {1'b1, 4'b0100}) begin n_bad++; $display("FAIL b2b_grant2: got v=%b rdy=%b, required 1 0100", rsp_valid, req_ready); end
        sb.push_back(mk(ta[2], tbv[2], 1'b1, 2'd2));
        @(negedge clk);
        req_valid = 4'b0000;
        drain();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        ta[2] = {$urandom, $urandom}; tbv[2] = {$urandom, $urandom};
        ta[0] = {$urandom, $urandom}; tbv[0] = {$urandom, $urandom};
        req_cin   = 4'b0000;
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        n_vec++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL rmid_grant2: got %b, required 0100", req_ready); end
        sb.push_back(mk(ta[2], tbv[2], 1'b0, 2'd2));
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        n_vec++; if ({rsp_valid, add_a} !== 65'd0) begin n_bad++; $display("FAIL rmid_add_reset: got v=%b add_a=%h, required 0 0", rsp_valid, add_a); end
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_no_rsp: got %b, required 0", rsp_valid); end
        @(negedge clk);
        req_valid = 4'b0101;
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL rmid_ptr_restart: got %b, required 0001", req_ready); end
        sb.push_back(mk(ta[0], tbv[0], 1'b0, 2'd0));
        @(negedge clk);
        req_valid = 4'b0100;
        @(negedge clk);
        #1;
        n_vec++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL rmid_grant2_after: got %b, required 0100", req_ready); end
        sb.push_back(mk(ta[2], tbv[2], 1'b0, 2'd2));
        @(negedge clk);
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        @(negedge clk);
        #1;
        n_vec++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rresp_pending: got %b, required 1", rsp_valid); end
        rst_n = 1'b0;
        sb.delete();
        #1;
        n_vec++; if ({rsp_valid, rsp_sum} !== 65'd0) begin n_bad++; $display("FAIL rresp_async_drop: got v=%b sum=%h, required 0 0", rsp_valid, rsp_sum); end
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rresp_no_rsp: got %b, required 0", rsp_valid); end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rotation();
        test_carry();
        test_stall();
        test_reset_mid();
        repeat (2) @(negedge clk);
        #3;
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL final_queue: got %0d outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
